data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the processor datapath's data-memory port.
- The datapath issues MemRead/MemWrite with an address and write data; this block answers them.
- Adds a configurable wait-state latency, registered read data, a one-cycle ready handshake and error reporting.
- Replaces a zero-latency combinational data memory, so the multicycle/stall-capable datapath can be exercised against realistic memory timing.

Parameters:
- DEPTH, 32, number of 32-bit words in the array; power of two, 2..1024.
- ADDR_BITS, 5, word-index width; must equal log2(DEPTH).
- WAIT_CYCLES, 2, wait states between accept and response; 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- MemRead  input  1  read request, level
- MemWrite  input  1  write request, level
- direc  input  32  byte address
- WriteData  input  32  store data
- ReadData  output  32  registered load data
- ready  output  1  one-cycle response strobe
- err  output  1  access error, valid only while ready=1
- busy  output  1  high while state != IDLE
- rd_count  output  16  completed reads (see Optional Feature)
- wr_count  output  16  completed writes (see Optional Feature)

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; ReadData=0, ready=0, err=0, busy=0, counters=0.
  - All DEPTH words cleared to 0.
  - A pending write that has not yet committed is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge where MemRead|MemWrite=1, latch direc, WriteData and the request type.
  - Go to WAIT with cnt=WAIT_CYCLES, or straight to RESP with access performed if WAIT_CYCLES=0.
  - Otherwise stay in IDLE.
- WAIT:
  - Inputs are ignored; latched values are used.
  - If cnt==1 at an edge: perform the access and go to RESP. Otherwise cnt decrements.
- RESP:
  - ready=1 for exactly one cycle; err valid.
  - Next edge always goes to IDLE. Requests present during RESP are not accepted.
  - The requester must drop or renew its request after seeing ready.
- Latency: ready is high in the cycle following the (WAIT_CYCLES+1)th rising edge after, and counting, the accepting edge.
- Access (performed at the edge entering RESP):
  - Word index = latched direc[ADDR_BITS+1:2].
  - Read: ReadData <= mem[index].
  - Write: mem[index] <= latched WriteData.
- ReadData holds its value until the next successful read. Writes and errored accesses do not change it.
- Error conditions (no memory access, ReadData unchanged, err=1 with ready):
  - Misaligned: direc[1:0] != 0.
  - Out of range: any of direc[31:ADDR_BITS+2] nonzero.
  - MemRead and MemWrite both 1 at accept.
- Back-to-back: after RESP the block is in IDLE, so a request held through RESP is accepted on the following edge. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Address wrap-around is not performed; out-of-range addresses are errors, never aliased.

Optional Feature:
- Macro DATA_MEM_RESPONDER_ACCESS_CNT_EN.
- When defined:
  - rd_count/wr_count increment by 1 on each error-free completed read/write, on the edge entering RESP.
  - They saturate at 16'hFFFF and are cleared by rst.
- When undefined: rd_count and wr_count are tied to 0 and no counter logic is built.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write direc=0x0000_0010, WriteData=0xDEAD_BEEF; ready in 3rd cycle after accept, err=0.
  - Then read 0x10 -> ReadData=0xDEAD_BEEF with ready, 3 cycles after accept.
- WAIT_CYCLES=0:
  - Read 0x0 after reset -> ready on the cycle after accept, ReadData=0x0000_0000.
  - busy high for exactly 1 cycle.
- Errors:
  - Read direc=0x0000_0006 -> ready+err=1, ReadData unchanged.
  - Write direc=0x0000_0080 (DEPTH=32) -> err=1, mem[0] unchanged.
  - MemRead=MemWrite=1 -> err=1.
- Reset mid-operation:
  - Write 0x1234_5678 to 0x4; assert rst in WAIT.
  - Outputs return to 0 immediately; subsequent read of 0x4 returns 0.
- Held request:
  - Keep MemRead=1 continuously at direc=0x8.
  - ready pulses every WAIT_CYCLES+2 cycles; ready is never high 2 cycles in a row.
- Counters, macro defined:
  - 3 good writes, 2 good reads, 1 misaligned read -> wr_count=3, rd_count=2.
  - With macro undefined both counters read 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: wait-state latency, registered read data, ready/err strobe.
// Optional access counters enabled by defining DATA_MEM_RESPONDER_ACCESS_CNT_EN.
module data_mem_responder #(
    parameter int DEPTH       = 32,
    parameter int ADDR_BITS   = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] direc,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]          acc_addr;
    logic [31:0]          acc_wdata;
    logic                 acc_rd;
    logic                 acc_wr;
    logic                 acc_bad;
    logic                 do_acc;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] acc_idx;

    // In IDLE the access (zero wait states) uses live inputs, otherwise the latched copy.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
        if (state_q == S_IDLE) begin
            acc_addr  = direc;
            acc_wdata = WriteData;
            acc_rd    = MemRead;
            acc_wr    = MemWrite;
        end
        acc_idx = acc_addr[ADDR_BITS+1:2];
        acc_bad = (acc_addr[1:0] != 2'b00)
               || ((acc_addr >> (ADDR_BITS + 2)) != 32'd0)
               || (acc_rd && acc_wr);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        do_acc  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = direc;
                    wdata_d = WriteData;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    if (WAIT_CYCLES == 0) begin
                        do_acc  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    do_acc  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (do_acc) begin
            err_d = acc_bad;
            if (!acc_bad && acc_rd) begin
                rdata_d = mem_q[acc_idx];
            end
        end
        mem_we = do_acc && !acc_bad && acc_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign ReadData = rdata_q;
    assign ready    = (state_q == S_RESP);
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);

`ifdef DATA_MEM_RESPONDER_ACCESS_CNT_EN
    logic [15:0] rdc_q, rdc_d;
    logic [15:0] wrc_q, wrc_d;

    always_comb begin
        rdc_d = rdc_q;
        wrc_d = wrc_q;
        if (do_acc && !acc_bad) begin
            if (acc_rd && rdc_q != 16'hFFFF) rdc_d = rdc_q + 16'd1;
            if (acc_wr && wrc_q != 16'hFFFF) wrc_d = wrc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdc_q <= '0;
            wrc_q <= '0;
        end else begin
            rdc_q <= rdc_d;
            wrc_q <= wrc_d;
        end
    end

    assign rd_count = rdc_q;
    assign wr_count = wrc_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder with a word-array reference model.
// Instance 0 runs with two wait states, instance 1 with none.
module tb_data_mem_responder;

    localparam int DEPTH = 32;
    localparam int WC [2] = '{2, 0};

    logic        clk;
    logic        rst;
    logic        mrd   [2];
    logic        mwr   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic        rdy   [2];
    logic        erro  [2];
    logic        bsy   [2];
    logic [15:0] rcnt  [2];
    logic [15:0] wcnt  [2];

    int nchecks = 0;
    int nerrors = 0;

    logic [31:0] mem_m   [2][DEPTH];
    logic [31:0] rdata_m [2];
    int          rdc_m   [2];
    int          wrc_m   [2];

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_BITS(5), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .MemRead(mrd[0]), .MemWrite(mwr[0]),
        .direc(addr[0]), .WriteData(wdat[0]),
        .ReadData(rdat[0]), .ready(rdy[0]), .err(erro[0]), .busy(bsy[0]),
        .rd_count(rcnt[0]), .wr_count(wcnt[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .ADDR_BITS(5), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .MemRead(mrd[1]), .MemWrite(mwr[1]),
        .direc(addr[1]), .WriteData(wdat[1]),
        .ReadData(rdat[1]), .ready(rdy[1]), .err(erro[1]), .busy(bsy[1]),
        .rd_count(rcnt[1]), .wr_count(wcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int c);
`ifdef DATA_MEM_RESPONDER_ACCESS_CNT_EN
        return (c > 65535) ? 32'h0000_FFFF : 32'(c);
`else
        return (c < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[s][i] = '0;
            rdata_m[s] = '0;
            rdc_m[s]   = 0;
            wrc_m[s]   = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mrd[s] = 1'b0; mwr[s] = 1'b0; addr[s] = '0; wdat[s] = '0;
        end
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    // Called just after a negedge with the instance idle.
    task automatic do_req(input int s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        logic bad;
        logic exp_err;
        int   n;
        int   nbusy;
        bit   seen;
        bad = (a % 4 != 0) || (a >= 32'(DEPTH * 4)) || (rd && wr);
        exp_err = bad;
        if (!bad && rd) begin
            rdata_m[s] = mem_m[s][a / 4];
            rdc_m[s]++;
        end
        if (!bad && wr) begin
            mem_m[s][a / 4] = d;
            wrc_m[s]++;
        end
        mrd[s] = rd; mwr[s] = wr; addr[s] = a; wdat[s] = d;
        n = 0; nbusy = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bsy[s]) nbusy++;
            if (rdy[s]) seen = 1;
        end
        chk("ready_seen", {31'd0, seen}, 32'd1);
        chk("latency", 32'(n), 32'(WC[s] + 1));
        chk("busy_cycles", 32'(nbusy), 32'(WC[s] + 1));
        chk("err", {31'd0, erro[s]}, {31'd0, exp_err});
        chk("rdata", rdat[s], rdata_m[s]);
        chk("rd_count", {16'd0, rcnt[s]}, exp_cnt(rdc_m[s]));
        chk("wr_count", {16'd0, wcnt[s]}, exp_cnt(wrc_m[s]));
        mrd[s] = 1'b0; mwr[s] = 1'b0;
        @(negedge clk);
        chk("ready_pulse", {31'd0, rdy[s]}, 32'd0);
        chk("idle_busy", {31'd0, bsy[s]}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          r;
        int          op;
        int          pulses;
        int          last;
        int          cyc;
        logic        prev;

        do_reset();
        chk("rst_rdata", rdat[0], 32'd0);
        chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
        chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
        chk("rst_err", {31'd0, erro[0]}, 32'd0);

        // zero-wait instance: read after reset, then write/read
        do_req(1, 1'b1, 1'b0, 32'h0, 32'h0);
        do_req(1, 1'b0, 1'b1, 32'h1C, 32'hA5A5_5A5A);
        do_req(1, 1'b1, 1'b0, 32'h1C, 32'h0);

        // write then read back
        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("readback", rdat[0], 32'hDEAD_BEEF);

        // errors
        do_req(0, 1'b1, 1'b0, 32'h6, 32'h0);
        do_req(0, 1'b0, 1'b1, 32'h80, 32'h1111_2222);
        do_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        do_req(0, 1'b1, 1'b1, 32'h8, 32'h3333_4444);

        // reset while waiting
        do_req(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        mwr[0] = 1'b1; addr[0] = 32'h4; wdat[0] = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, rdy[0]}, 32'd0);
        chk("mid_rst_busy", {31'd0, bsy[0]}, 32'd0);
        chk("mid_rst_rdata", rdat[0], 32'd0);
        @(negedge clk);
        mwr[0] = 1'b0;
        model_reset();
        rst = 1'b0;
        do_req(0, 1'b1, 1'b0, 32'h4, 32'h0);

        // counters from a clean start
        do_reset();
        for (int i = 0; i < 3; i++) do_req(0, 1'b0, 1'b1, 32'(4 * (i + 3)), $urandom);
        for (int i = 0; i < 2; i++) do_req(0, 1'b1, 1'b0, 32'(4 * (i + 3)), 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0002, 32'h0);
`ifdef DATA_MEM_RESPONDER_ACCESS_CNT_EN
        chk("wr_count_3", {16'd0, wcnt[0]}, 32'd3);
        chk("rd_count_2", {16'd0, rcnt[0]}, 32'd2);
`else
        chk("wr_count_off", {16'd0, wcnt[0]}, 32'd0);
        chk("rd_count_off", {16'd0, rcnt[0]}, 32'd0);
`endif

        // held read request
        mrd[0] = 1'b1; addr[0] = 32'h8;
        pulses = 0; last = -1; cyc = 0; prev = 1'b0;
        while (pulses < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("no_b2b", {31'd0, rdy[0] && prev}, 32'd0);
            prev = rdy[0];
            if (rdy[0]) begin
                pulses++;
                rdata_m[0] = mem_m[0][2];
                rdc_m[0]++;
                chk("held_rdata", rdat[0], rdata_m[0]);
                if (last >= 0) chk("held_gap", 32'(cyc - last), 32'(WC[0] + 2));
                last = cyc;
            end
        end
        chk("held_pulses", 32'(pulses), 32'd4);
        mrd[0] = 1'b0;
        @(negedge clk);
        chk("held_idle", {31'd0, bsy[0]}, 32'd0);

        // randomized traffic on both instances
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 8) a = $urandom | 32'h80;
            else             a = $urandom;
            d  = $urandom;
            op = $urandom_range(0, 9);
            do_req(i % 2, op < 5 || op == 9, op >= 5, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
